apb_uart_bridge: RTL
====================

APB_UART_BRIDGE -- requirements
Module: apb_uart_bridge

Interface
REQ-001 SHALL have parameter TX_ADDR, default 'h10, the PADDR value of the transmit-data register (write-only).
REQ-002 SHALL have parameter RX_ADDR, default 'h14, the PADDR value of the receive-data register (read-only).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 24'd2_000_000, the number of ACCESS cycles to wait for core ready before an error response.
REQ-004 PCLK  input  1  APB clock; all state is updated on the rising edge.
REQ-005 PRESETn  input  1  reset, asynchronous assert, active-low.
REQ-006 PSEL, PENABLE, PWRITE  input  1 each  APB control.
REQ-007 PADDR  input  `ADDR_WIDTH  APB address.
REQ-008 PWDATA  input  `DATA_WIDTH  APB write data.
REQ-009 PRDATA  output  `DATA_WIDTH  APB read data.
REQ-010 PREADY, PSLVERR  output  1 each  APB completion and error.
REQ-011 write_data_in  output  `DATA_WIDTH  captured PWDATA to the UART core.
REQ-012 config_address  output  `ADDR_WIDTH  captured PADDR to the UART core.
REQ-013 TX_detect, RX_detect, config_write_detect, config_read_detect  output  1 each  one-hot operation strobes to the core.
REQ-014 read_data  input  `DATA_WIDTH; ready  input  1; error  input  1  core response signals.

Function
REQ-015 The FSM SHALL have the states IDLE, SETUP, ACCESS and RESP.
REQ-016 IDLE: on PSEL=1 and PENABLE=0, the block SHALL capture PADDR, PWDATA and PWRITE into registers and go to SETUP.
REQ-017 SETUP: the block SHALL decode the captured address.
- Valid operation: go to ACCESS.
- Illegal operation: go to RESP with err_flag=1 and rdata=0.
- Illegal means an unmapped address, a write to RX_ADDR, or a read of TX_ADDR.
REQ-018 Decode SHALL be as follows:
- TX_ADDR with write: TX_detect.
- RX_ADDR with read: RX_detect.
- `baud_config, `frame_config, `parity_config or `stop_bits_config: config_write_detect if PWRITE=1, else config_read_detect.
REQ-019 ACCESS: exactly one detect strobe SHALL be high, and write_data_in/config_address SHALL hold the captured values stable.
REQ-020 The wait counter SHALL clear on entry to ACCESS and increment each ACCESS cycle.
REQ-021 In ACCESS, ready SHALL be ignored in the first cycle, so stale ready from a previous operation cannot complete a new one.
REQ-022 In ACCESS from the second cycle onward, when ready=1 the block SHALL latch read_data (reads only, else 0) into rdata and error into err_flag, drop the strobe, and go to RESP.
REQ-023 In ACCESS, when the counter reaches TIMEOUT_CYCLES-1 without ready, the block SHALL drop the strobe, set err_flag=1 and rdata=0, and go to RESP.
REQ-024 RESP: the block SHALL drive PREADY=1, PRDATA=rdata and PSLVERR=err_flag for exactly one cycle, with all strobes 0, then go to IDLE.
REQ-025 Outside RESP, PREADY, PSLVERR and PRDATA SHALL be 0.
REQ-026 If PSEL falls in SETUP or ACCESS, the block SHALL abort to IDLE, drop the strobe, and give no PREADY pulse.
REQ-027 Back-to-back transfers SHALL have a minimum spacing of IDLE→SETUP→ACCESS(≥2)→RESP, giving a latency of at least 4 cycles from PSEL rise to PREADY.
REQ-028 The wait counter SHALL be 24 bits and saturating; it SHALL never wrap.

Reset
REQ-029 On PRESETn=0, asynchronously and regardless of state, the block SHALL enter IDLE and clear:
- PRDATA, PREADY, PSLVERR, all four strobes, write_data_in, config_address, the counter and the capture registers.
REQ-030 On release of PRESETn, the block SHALL start in IDLE with no pending transfer.

Verification
REQ-031 Config write: PADDR=`baud_config, PWDATA=115200, with ready in the 2nd ACCESS cycle → config_write_detect high for 2 cycles, then one PREADY pulse with PSLVERR=0.
REQ-032 RX read: PADDR=RX_ADDR, read_data='hA5, ready in the 3rd ACCESS cycle → PRDATA='hA5 for exactly the PREADY cycle, 0 otherwise.
REQ-033 Illegal access: write to RX_ADDR or read of 'h3C → no strobe, PREADY one cycle after SETUP, PSLVERR=1, PRDATA=0.
REQ-034 Timeout: TIMEOUT_CYCLES=16, TX write with ready held 0 → TX_detect high for 16 cycles, then PREADY=1 with PSLVERR=1.
REQ-035 Stale ready: ready held 1 on entry to ACCESS → no completion in the first ACCESS cycle, completion in the second.
REQ-036 Reset mid-ACCESS: PRESETn low while TX_detect=1 → all outputs 0 immediately, without waiting for a clock edge; the next transfer completes normally.

Source files
------------

// File: rtl/apb_uart_bridge.sv
// apb_uart_bridge: APB slave front end for a UART core. Turns an APB transfer
// into one registered operation strobe, waits for the core's ready with a
// timeout, and answers the APB master with a single PREADY pulse.

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 8
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef BAUD_CONFIG
`define BAUD_CONFIG 8'h00
`endif
`ifndef FRAME_CONFIG
`define FRAME_CONFIG 8'h04
`endif
`ifndef PARITY_CONFIG
`define PARITY_CONFIG 8'h08
`endif
`ifndef STOP_BITS_CONFIG
`define STOP_BITS_CONFIG 8'h0C
`endif

module apb_uart_bridge #(
  parameter logic [`ADDR_WIDTH-1:0] TX_ADDR        = 'h10,
  parameter logic [`ADDR_WIDTH-1:0] RX_ADDR        = 'h14,
  parameter logic [23:0]            TIMEOUT_CYCLES = 24'd2_000_000
) (
  input  logic                    PCLK,
  input  logic                    PRESETn,
  input  logic                    PSEL,
  input  logic                    PENABLE,
  input  logic                    PWRITE,
  input  logic [`ADDR_WIDTH-1:0]  PADDR,
  input  logic [`DATA_WIDTH-1:0]  PWDATA,
  output logic [`DATA_WIDTH-1:0]  PRDATA,
  output logic                    PREADY,
  output logic                    PSLVERR,
  output logic [`DATA_WIDTH-1:0]  write_data_in,
  output logic [`ADDR_WIDTH-1:0]  config_address,
  output logic                    TX_detect,
  output logic                    RX_detect,
  output logic                    config_write_detect,
  output logic                    config_read_detect,
  input  logic [`DATA_WIDTH-1:0]  read_data,
  input  logic                    ready,
  input  logic                    error
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t                   state_q, state_d;
  logic [`ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [`DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                     write_q, write_d;
  logic [23:0]              cnt_q, cnt_d;
  logic [`DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                     err_q, err_d;

  logic is_cfg, op_tx, op_rx, op_cw, op_cr, op_valid;

  // Decode the captured address/direction into the four core operations.
  always_comb begin
    is_cfg   = (addr_q == `BAUD_CONFIG) || (addr_q == `FRAME_CONFIG) ||
               (addr_q == `PARITY_CONFIG) || (addr_q == `STOP_BITS_CONFIG);
    op_tx    = (addr_q == TX_ADDR) && write_q;
    op_rx    = (addr_q == RX_ADDR) && !write_q;
    op_cw    = is_cfg && write_q;
    op_cr    = is_cfg && !write_q;
    op_valid = op_tx || op_rx || op_cw || op_cr;
  end

  // Transfer sequencing; the first ACCESS cycle (cnt_q == 0) ignores ready so a stale ready cannot complete a new operation.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    write_d = write_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (PSEL && !PENABLE) begin
          addr_d  = PADDR;
          wdata_d = PWDATA;
          write_d = PWRITE;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (!PSEL) begin
          state_d = IDLE;
        end else if (op_valid) begin
          cnt_d   = '0;
          state_d = ACCESS;
        end else begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = RESP;
        end
      end
      ACCESS: begin
        if (!PSEL) begin
          state_d = IDLE;
        end else if ((cnt_q != '0) && ready) begin
          rdata_d = write_q ? '0 : read_data;
          err_d   = error;
          state_d = RESP;
        end else if (cnt_q >= (TIMEOUT_CYCLES - 24'd1)) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else if (cnt_q != 24'hFF_FFFF) begin
          cnt_d = cnt_q + 24'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and capture registers, cleared asynchronously by PRESETn.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Outputs are pure functions of registered state, so reset clears them without a clock.
  always_comb begin
    PREADY              = (state_q == RESP);
    PSLVERR             = (state_q == RESP) && err_q;
    PRDATA              = (state_q == RESP) ? rdata_q : '0;
    TX_detect           = (state_q == ACCESS) && op_tx;
    RX_detect           = (state_q == ACCESS) && op_rx;
    config_write_detect = (state_q == ACCESS) && op_cw;
    config_read_detect  = (state_q == ACCESS) && op_cr;
    write_data_in       = wdata_q;
    config_address      = addr_q;
  end

endmodule
